// File: rtl/driver_button_array.sv
// Synchronises, polarity-normalises and debounces a bank of buttons; emits press/release/long pulses.
// Latency: P_SYNC_STAGES cycles pin->button_signal; filtered/events follow P_DEBOUNCE_TICKS ticks later.
// Backpressure: none; pulses are one-cycle strobes that the consumer must sample every clock.
module driver_button_array #(
    parameter int   P_CHANNELS            = 4,
    parameter logic P_BUTTON_ACTIVE_LEVEL = 1'b0,
    parameter int   P_SYNC_STAGES         = 2,
    parameter int   P_DEBOUNCE_TICKS      = 4,
    parameter int   P_LONG_TICKS          = 100
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  tick,
    input  logic [P_CHANNELS-1:0] gpio_button,
    output logic [P_CHANNELS-1:0] button_signal,
    output logic [P_CHANNELS-1:0] button_filtered,
    output logic [P_CHANNELS-1:0] button_press,
    output logic [P_CHANNELS-1:0] button_release,
    output logic [P_CHANNELS-1:0] button_long
);

    localparam int CNT_MAX = (P_DEBOUNCE_TICKS > P_LONG_TICKS) ? P_DEBOUNCE_TICKS : P_LONG_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(P_DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(P_LONG_TICKS);
    localparam bit LONG_EN = (P_LONG_TICKS != 0);
    localparam logic [P_CHANNELS-1:0] INACTIVE = {P_CHANNELS{~P_BUTTON_ACTIVE_LEVEL}};

    typedef enum logic [1:0] {IDLE, PRESS_DEB, PRESSED, RELEASE_DEB} state_t;

    logic [P_CHANNELS-1:0] sync_q [P_SYNC_STAGES];
    logic [1:0]            en_q;
    logic                  en_s;

    always_ff @(posedge aclk) begin
        if (reset) begin
            for (int s = 0; s < P_SYNC_STAGES; s++) begin
                sync_q[s] <= INACTIVE;
            end
            en_q <= 2'b00;
        end else begin
            sync_q[0] <= gpio_button;
            for (int s = 1; s < P_SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            en_q <= {en_q[0], en};
        end
    end

    assign en_s          = en_q[1];
    assign button_signal = ~(sync_q[P_SYNC_STAGES-1] ^ {P_CHANNELS{P_BUTTON_ACTIVE_LEVEL}});

    for (genvar g = 0; g < P_CHANNELS; g++) begin : g_ch
        state_t        state_q, state_n;
        logic [CW-1:0] dcnt_q, dcnt_n;
        logic [CW-1:0] hcnt_q, hcnt_n;
        logic          long_done_q, long_done_n;
        logic          filt_q, press_q, rel_q, long_q;
        logic          filt_n, press_n, rel_n, long_n;
        logic          raw;

        assign raw = button_signal[g];

        always_comb begin
            state_n     = state_q;
            dcnt_n      = dcnt_q;
            hcnt_n      = hcnt_q;
            long_done_n = long_done_q;
            press_n     = 1'b0;
            rel_n       = 1'b0;
            long_n      = 1'b0;

            // Hold timer runs through release debounce so a bounce never restarts it.
            if ((state_q == PRESSED || state_q == RELEASE_DEB) && tick && hcnt_q != LONG_MAX) begin
                hcnt_n = hcnt_q + 1'b1;
                if (LONG_EN && !long_done_q && hcnt_n == LONG_MAX) begin
                    long_n      = 1'b1;
                    long_done_n = 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    dcnt_n      = '0;
                    hcnt_n      = '0;
                    long_done_n = 1'b0;
                    if (raw) begin
                        state_n = PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    if (!raw) begin
                        state_n = IDLE;
                    end else if (tick) begin
                        if (dcnt_q == DEB_LAST) begin
                            state_n     = PRESSED;
                            press_n     = 1'b1;
                            hcnt_n      = '0;
                            long_done_n = 1'b0;
                        end else begin
                            dcnt_n = dcnt_q + 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!raw) begin
                        state_n = RELEASE_DEB;
                        dcnt_n  = '0;
                    end
                end
                RELEASE_DEB: begin
                    if (raw) begin
                        state_n = PRESSED;
                    end else if (tick) begin
                        if (dcnt_q == DEB_LAST) begin
                            state_n = IDLE;
                            rel_n   = 1'b1;
                        end else begin
                            dcnt_n = dcnt_q + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase

            if (!en_s) begin
                state_n     = IDLE;
                dcnt_n      = '0;
                hcnt_n      = '0;
                long_done_n = 1'b0;
                press_n     = 1'b0;
                rel_n       = 1'b0;
                long_n      = 1'b0;
            end

            filt_n = (state_n == PRESSED) || (state_n == RELEASE_DEB);
        end

        always_ff @(posedge aclk) begin
            if (reset) begin
                state_q     <= IDLE;
                dcnt_q      <= '0;
                hcnt_q      <= '0;
                long_done_q <= 1'b0;
                filt_q      <= 1'b0;
                press_q     <= 1'b0;
                rel_q       <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                state_q     <= state_n;
                dcnt_q      <= dcnt_n;
                hcnt_q      <= hcnt_n;
                long_done_q <= long_done_n;
                filt_q      <= filt_n;
                press_q     <= press_n;
                rel_q       <= rel_n;
                long_q      <= long_n;
            end
        end

        assign button_filtered[g] = filt_q;
        assign button_press[g]    = press_q;
        assign button_release[g]  = rel_q;
        assign button_long[g]     = long_q;
    end

endmodule
